// File: rtl/text_column_capture.sv
// Captures one 8-pixel band of vertically rendered text into a double-buffered
// column store and serves the front buffer to the LED-matrix refresh logic.
module text_column_capture #(
  parameter int unsigned TEXT_WIDTH    = 16,
  parameter int unsigned CHAR_WIDTH    = 8,
  parameter int unsigned PIXEL_ROWS    = 8,
  parameter int unsigned SETTLE_CYCLES = 4,
  localparam int unsigned COLS    = TEXT_WIDTH * CHAR_WIDTH,
  localparam int unsigned COL_SZ  = $clog2(COLS),
  localparam int unsigned BAND_SZ = $clog2(PIXEL_ROWS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [BAND_SZ-1:0] band_sel,
  output logic               busy,
  output logic               done,
  output logic               toggle_restart,
  output logic               toggle_next,
  input  logic [7:0]         cur_pixels,
  input  logic [COL_SZ-1:0]  rd_col,
  output logic [7:0]         rd_data
);

  localparam int unsigned CNT_SZ  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned SKIP_SZ = $clog2(PIXEL_ROWS * COLS);

  localparam logic [CNT_SZ-1:0] CNT_RELOAD = CNT_SZ'(SETTLE_CYCLES - 1);
  localparam logic [COL_SZ-1:0] COL_LAST   = COL_SZ'(COLS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    STEP = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [CNT_SZ-1:0]   cnt, cnt_next;
  logic [SKIP_SZ-1:0]  skip, skip_next;
  logic [COL_SZ-1:0]   col, col_next;
  logic                toggle_restart_next, toggle_next_next;
  logic                busy_next, done_next;
  logic                front_sel, front_sel_next;
  logic                wr_en;

  logic [7:0] mem [2][COLS];

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next          = state;
    cnt_next            = cnt;
    skip_next           = skip;
    col_next            = col;
    toggle_restart_next = toggle_restart;
    toggle_next_next    = toggle_next;
    busy_next           = busy;
    done_next           = 1'b0;
    front_sel_next      = front_sel;
    wr_en               = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          toggle_restart_next = ~toggle_restart;
          // Columns of earlier bands are stepped over without capturing.
          skip_next           = SKIP_SZ'(band_sel) * SKIP_SZ'(COLS);
          col_next            = '0;
          cnt_next            = CNT_RELOAD;
          busy_next           = 1'b1;
          state_next          = WAIT;
        end
      end

      WAIT: begin
        if (cnt == '0) begin
          state_next = STEP;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end

      STEP: begin
        if (skip != '0) begin
          skip_next        = skip - 1'b1;
          toggle_next_next = ~toggle_next;
          cnt_next         = CNT_RELOAD;
          state_next       = WAIT;
        end else begin
          wr_en = 1'b1;
          if (col == COL_LAST) begin
            front_sel_next = ~front_sel;
            busy_next      = 1'b0;
            done_next      = 1'b1;
            state_next     = IDLE;
          end else begin
            col_next         = col + 1'b1;
            toggle_next_next = ~toggle_next;
            cnt_next         = CNT_RELOAD;
            state_next       = WAIT;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      skip           <= '0;
      col            <= '0;
      toggle_restart <= 1'b0;
      toggle_next    <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      front_sel      <= 1'b0;
    end else begin
      state          <= state_next;
      cnt            <= cnt_next;
      skip           <= skip_next;
      col            <= col_next;
      toggle_restart <= toggle_restart_next;
      toggle_next    <= toggle_next_next;
      busy           <= busy_next;
      done           <= done_next;
      front_sel      <= front_sel_next;
    end
  end

  // NOTE: the column store has no reset so it maps onto plain RAM; the
  // front buffer is only meaningful after a completed capture.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem[~front_sel][col] <= cur_pixels;
    end
  end

  // front_sel is still the old value on the swap edge, so reads never tear.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[front_sel][rd_col];
    end
  end

endmodule

// File: tb/tb_text_column_capture.sv
// Directed bench for text_column_capture with a behavioural generator model
// that only presents valid pixels SETTLE_CYCLES+1 edges after each toggle.
module tb_text_column_capture;

  localparam int unsigned SETTLE_CYCLES = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] band_sel;
  logic       busy;
  logic       done;
  logic       toggle_restart;
  logic       toggle_next;
  logic [7:0] cur_pixels = 8'hFF;
  logic [6:0] rd_col;
  logic [7:0] rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  text_column_capture #(
    .TEXT_WIDTH   (16),
    .CHAR_WIDTH   (8),
    .PIXEL_ROWS   (8),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .band_sel      (band_sel),
    .busy          (busy),
    .done          (done),
    .toggle_restart(toggle_restart),
    .toggle_next   (toggle_next),
    .cur_pixels    (cur_pixels),
    .rd_col        (rd_col),
    .rd_data       (rd_data)
  );

  always #5 clk = ~clk;

  // Generator model: restart rewinds to column 0, next advances one column.
  // Pixels read {band, col[4:0]} once settled and 8'hFF while settling.
  logic       tr_q = 1'b0;
  logic       tn_q = 1'b0;
  logic       rst_seen = 1'b1;
  logic [9:0] gen_idx = '0;
  int         settle = 0;
  int         rs_flips = 0;
  int         nx_flips = 0;
  int         simul = 0;

  always @(posedge clk) rst_seen <= reset;

  always @(negedge clk) begin
    if (!rst_seen && toggle_restart != tr_q && toggle_next != tn_q) simul++;
    if (toggle_restart != tr_q) begin
      rs_flips++;
      gen_idx = '0;
      settle  = SETTLE_CYCLES + 1;
    end else if (toggle_next != tn_q) begin
      nx_flips++;
      gen_idx = gen_idx + 1'b1;
      settle  = SETTLE_CYCLES + 1;
    end
    tr_q = toggle_restart;
    tn_q = toggle_next;
    if (settle > 0) settle--;
    cur_pixels = (settle == 0) ? {gen_idx[9:7], gen_idx[4:0]} : 8'hFF;
  end

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // The edge inside this task is E0.
  task automatic start_capture(input logic [2:0] band);
    band_sel = band;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int edge_no);
    edge_no = 0;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (done) begin
        edge_no = i;
        break;
      end
    end
    if (edge_no == 0) check("done_timeout", 0, 1);
  endtask

  task automatic read_all(input string tag, input logic [2:0] band);
    for (int c = 0; c < 128; c++) begin
      logic [6:0] cc;
      cc = 7'(c);
      rd_col = cc;
      tick();
      check(tag, rd_data, {band, cc[4:0]});
    end
  endtask

  initial begin
    int d, d1, d2, n_done, rs0, nx0, simul_cnt;
    reset    = 1'b1;
    start    = 1'b0;
    band_sel = '0;
    rd_col   = '0;
    repeat (3) tick();

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tr", toggle_restart, 0);
    check("rst_tn", toggle_next, 0);
    check("rst_rd", rd_data, 0);
    reset = 1'b0;
    tick();

    // Band 0: col 127 captured at E640, done in the following cycle
    start_capture(3'd0);
    check("b0_busy", busy, 1);
    wait_done(800, d);
    check("b0_done_edge", d, 640);
    check("b0_busy_end", busy, 0);
    tick();
    check("b0_done_pulse", done, 0);
    read_all("b0_rd", 3'd0);

    // Band 5: 640 skips + 127 steps, one restart
    rs0 = rs_flips;
    nx0 = nx_flips;
    start_capture(3'd5);
    wait_done(5000, d);
    check("b5_done_edge", d, 3840);
    check("b5_restart_flips", rs_flips - rs0, 1);
    check("b5_next_flips", nx_flips - nx0, 767);
    read_all("b5_rd", 3'd5);

    // Band 2 with continuous reads: old front (band 5) until after the swap
    rd_col = 7'd3;
    tick();
    start_capture(3'd2);
    d = 0;
    for (int i = 1; i <= 2500; i++) begin
      tick();
      check("tear_old", rd_data, {3'd5, 5'd3});
      if (done) begin
        d = i;
        break;
      end
    end
    check("b2_done_edge", d, 1920);
    tick();
    check("tear_new", rd_data, {3'd2, 5'd3});

    // start held through the capture and 3 cycles past done
    band_sel = 3'd0;
    start    = 1'b1;
    tick();
    n_done = 0;
    d1 = 0;
    d2 = 0;
    for (int i = 1; i <= 1400; i++) begin
      tick();
      if (done) begin
        n_done++;
        if (n_done == 1) d1 = i;
        else d2 = i;
      end
      if (n_done == 1 && i == d1 + 1) check("held_rebusy", busy, 1);
      if (n_done == 1 && i == d1 + 3) start = 1'b0;
    end
    start = 1'b0;
    check("held_done_cnt", n_done, 2);
    check("held_d1", d1, 640);
    check("held_d2", d2, 1281);
    read_all("held_rd", 3'd0);

    // Two more captures: buffer 0 <- band 4, buffer 1 <- band 6 (front)
    start_capture(3'd4);
    wait_done(4000, d);
    check("b4_done_edge", d, 3200);
    start_capture(3'd6);
    wait_done(5000, d);
    check("b6_done_edge", d, 4480);
    read_all("b6_rd", 3'd6);

    // Reset at cycle 300 of a band 7 capture: no done, front back to buffer 0
    start_capture(3'd7);
    repeat (299) tick();
    reset = 1'b1;
    tick();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_rd", rd_data, 0);
    reset = 1'b0;
    n_done = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (done) n_done++;
    end
    check("mid_rst_no_done", n_done, 0);
    check("mid_rst_busy_idle", busy, 0);
    read_all("mid_rst_front0", 3'd4);

    // Normal band 0 capture after the aborted one
    start_capture(3'd0);
    wait_done(800, d);
    check("post_rst_done_edge", d, 640);
    read_all("post_rst_rd", 3'd0);

    simul_cnt = simul;
    check("simultaneous_flips", simul_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
